shader_spi_loader: RTL and testbench

- SPI target that loads shader program bytes into the tiny shader's instruction memory and sets its user-input register.
- Sits between the bidirectional PMOD SPI pins and the shader core.
- Sequences every instruction-memory write so it never collides with shader instruction fetch; the shader's `exec_active` arbitrates access.
- All logic runs in the pixel clock domain; SPI pins are oversampled.

---
 rtl/shader_spi_loader.sv | 185 ++++++++++++++++++
 tb/tb_shader_spi_loader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/shader_spi_loader.sv
// SPI target that loads shader instruction bytes and the user-input register, committing writes only when shader fetch is idle.
// Define SPI_READBACK_EN to compile in the STATUS readback path on spi_miso.
module shader_spi_loader #(
  parameter int PROG_DEPTH = 16,
  localparam int ADDR_W = $clog2(PROG_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  input  logic              exec_active,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [7:0]        user_reg,
  output logic              overflow
);

  typedef enum logic [2:0] {IDLE, CMD, PROG, USER, STATUS, IGNORE} state_t;

  state_t state_q, state_d;

  logic [2:0]        sclk_sync;
  logic [1:0]        mosi_sync, cs_sync;
  logic              cs_prev;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_q;
  logic              pending_q;
  logic [ADDR_W-1:0] ptr_q, hold_addr, last_addr;
  logic [7:0]        hold_data, last_data;

  logic prog_byte, user_load, ovf_clr, ptr_clr, commit;

  // Three flops on sclk: two for metastability, the third for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= 2'b11;
      cs_prev   <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sclk_sync <= {sclk_sync[1:0], spi_sclk};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      cs_prev   <= cs_sync[1];
    end
  end

  logic       cs_s, cs_fall, sclk_rise, byte_done;
  logic [7:0] rx_byte;
  assign cs_s      = cs_sync[1];
  assign cs_fall   = cs_prev & ~cs_s;
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign byte_done = ~cs_s & sclk_rise & (bit_cnt == 3'd7);
  assign rx_byte   = {shift_q[6:0], mosi_sync[1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shift_q <= '0;
    end else if (cs_s) begin
      bit_cnt <= '0;
    end else if (sclk_rise) begin
      shift_q <= rx_byte;
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

`ifdef SPI_READBACK_EN
  logic status_start;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d   = state_q;
    prog_byte = 1'b0;
    user_load = 1'b0;
    ovf_clr   = 1'b0;
    ptr_clr   = 1'b0;
`ifdef SPI_READBACK_EN
    status_start = 1'b0;
`endif
    if (cs_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (cs_fall) state_d = CMD;
        CMD: if (byte_done) begin
          case (rx_byte)
            8'h01: begin state_d = PROG; ptr_clr = 1'b1; end
            8'h02: state_d = USER;
`ifdef SPI_READBACK_EN
            8'h03: begin state_d = STATUS; status_start = 1'b1; end
`endif
            8'h04: begin state_d = IGNORE; ovf_clr = 1'b1; end
            default: state_d = IGNORE;
          endcase
        end
        PROG: prog_byte = byte_done;
        USER: if (byte_done) begin
          user_load = 1'b1;
          state_d   = IGNORE;
        end
        STATUS, IGNORE: state_d = state_q;
        default: state_d = IDLE;
      endcase
    end
  end

  // A commit in the same cycle frees the holding register, so a coincident byte is accepted.
  assign commit    = pending_q & ~exec_active;
  assign mem_we    = commit;
  assign mem_addr  = commit ? hold_addr : last_addr;
  assign mem_wdata = commit ? hold_data : last_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      ptr_q     <= '0;
      hold_addr <= '0;
      hold_data <= '0;
      last_addr <= '0;
      last_data <= '0;
      user_reg  <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (commit) begin
        last_addr <= hold_addr;
        last_data <= hold_data;
      end
      if (prog_byte && (!pending_q || commit)) begin
        hold_addr <= ptr_q;
        hold_data <= rx_byte;
        pending_q <= 1'b1;
        ptr_q     <= (ptr_q == ADDR_W'(PROG_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
      end else begin
        if (prog_byte) overflow <= 1'b1;
        if (commit) pending_q <= 1'b0;
      end
      if (ptr_clr) ptr_q <= '0;
      if (ovf_clr) overflow <= 1'b0;
      if (user_load) user_reg <= rx_byte;
    end
  end

`ifdef SPI_READBACK_EN
  logic       sclk_fall, status_armed, miso_q;
  logic [7:0] status_sr;
  logic [5:0] ptr6;
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign ptr6      = 6'(ptr_q);

  // The command byte's own trailing fall must not shift; arm on the first rise inside STATUS.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miso_q       <= 1'b0;
      status_sr    <= '0;
      status_armed <= 1'b0;
    end else if (status_start) begin
      miso_q       <= overflow;
      status_sr    <= {pending_q, ptr6, 1'b0};
      status_armed <= 1'b0;
    end else if (state_q != STATUS) begin
      miso_q       <= 1'b0;
      status_sr    <= '0;
      status_armed <= 1'b0;
    end else begin
      if (sclk_rise) status_armed <= 1'b1;
      if (sclk_fall && status_armed) begin
        miso_q    <= status_sr[7];
        status_sr <= {status_sr[6:0], 1'b0};
      end
    end
  end
  assign spi_miso = miso_q;
`else
  assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_shader_spi_loader.sv
// Directed self-checking bench for shader_spi_loader: load, arbitration, wrap, overflow, user register, abort, readback.
module tb_shader_spi_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       exec_active = 1'b0;
  logic       spi_miso, mem_we, overflow;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, user_reg;

  shader_spi_loader #(.PROG_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso),
    .exec_active(exec_active),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .user_reg(user_reg), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [11:0] wr_q[$];
  bit         miso_seen = 1'b0;

  // Write log sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
    if (spi_miso) miso_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    step(8);
  endtask

  task automatic cs_high();
    step(8);
    spi_cs_n = 1'b1;
    step(8);
  endtask

  // Mode 0, MSB first, sclk = clk/16; MISO is sampled just before each rising sclk.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      step(8);
      rx = {rx[6:0], spi_miso};
      spi_sclk = 1'b1;
      step(8);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] rx;
    spi_bits(tx, 8, rx);
  endtask

  initial begin
    logic [7:0] rx;

    step(4);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 4'h0);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    check("rst_user_reg", user_reg, 8'h00);
    check("rst_overflow", overflow, 1'b0);
    check("rst_miso", spi_miso, 1'b0);
    rst_n = 1'b1;
    step(4);

    // Program load
    wr_q.delete();
    cs_low(); send(8'h01); send(8'hA5); send(8'h3C); cs_high();
    check("load_count", wr_q.size(), 2);
    check("load_wr0", wr_q[0], {4'h0, 8'hA5});
    check("load_wr1", wr_q[1], {4'h1, 8'h3C});
    check("load_overflow", overflow, 1'b0);

    // Arbitration
    exec_active = 1'b1;
    wr_q.delete();
    cs_low(); send(8'h01); send(8'h55); cs_high();
    step(20);
    check("arb_blocked", wr_q.size(), 0);
    exec_active = 1'b0;
    @(negedge clk);
    check("arb_we", mem_we, 1'b1);
    check("arb_addr", mem_addr, 4'h0);
    check("arb_data", mem_wdata, 8'h55);
    step(4);
    check("arb_count", wr_q.size(), 1);

    // Wrap
    wr_q.delete();
    cs_low(); send(8'h01);
    for (int b = 0; b < 17; b++) send(8'(b));
    cs_high();
    check("wrap_count", wr_q.size(), 17);
    check("wrap_wr15", wr_q[15], {4'hF, 8'h0F});
    check("wrap_wr16", wr_q[16], {4'h0, 8'h10});

    // Overflow and clear
    exec_active = 1'b1;
    wr_q.delete();
    cs_low(); send(8'h01); send(8'h20); send(8'h21); cs_high();
    check("ovf_set", overflow, 1'b1);
    check("ovf_no_write", wr_q.size(), 0);
    exec_active = 1'b0;
    step(4);
    check("ovf_count", wr_q.size(), 1);
    check("ovf_wr0", wr_q[0], {4'h0, 8'h20});
    cs_low(); send(8'h04); cs_high();
    check("ovf_clear", overflow, 1'b0);

    // User register
    wr_q.delete();
    cs_low(); send(8'h02); send(8'h7E); send(8'hFF); cs_high();
    check("user_reg", user_reg, 8'h7E);
    check("user_no_write", wr_q.size(), 0);

    // Abort mid-byte
    wr_q.delete();
    cs_low(); send(8'h01); spi_bits(8'hE7, 5, rx); cs_high();
    step(8);
    check("abort_no_write", wr_q.size(), 0);
    cs_low(); send(8'h01); send(8'h11); cs_high();
    check("abort_count", wr_q.size(), 1);
    check("abort_wr0", wr_q[0], {4'h0, 8'h11});

    // Status readback: overflow=1, pending=0, pointer=3
    wr_q.delete();
    cs_low(); send(8'h01); send(8'hB0); send(8'hB1);
    exec_active = 1'b1;
    send(8'hB2); send(8'hB3); cs_high();
    check("rb_overflow", overflow, 1'b1);
    exec_active = 1'b0;
    step(4);
    check("rb_count", wr_q.size(), 3);
    check("rb_wr2", wr_q[2], {4'h2, 8'hB2});
    cs_low(); send(8'h03); spi_bits(8'h00, 8, rx); cs_high();
`ifdef SPI_READBACK_EN
    check("rb_status", rx, 8'h83);
`else
    check("rb_status_off", rx, 8'h00);
    check("rb_miso_never_high", miso_seen, 1'b0);
`endif
    cs_low(); send(8'h04); cs_high();
    check("rb_ovf_clear", overflow, 1'b0);
    check("final_miso", spi_miso, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
